// File: rtl/arb2_mux.sv
// Two-input round-robin arbitrated mux with valid/ready inputs and a single-entry output register.
// Optional packet locking (last-beat aware) is enabled with `define ARB2_MUX_LAST_LOCK_EN.
module arb2_mux #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RESETN,
  input  logic [WIDTH-1:0] I0,
  input  logic             I0_valid,
  output logic             I0_ready,
  input  logic [WIDTH-1:0] I1,
  input  logic             I1_valid,
  output logic             I1_ready,
  output logic [WIDTH-1:0] O,
  output logic             O_valid,
  input  logic             O_ready,
  output logic             S
`ifdef ARB2_MUX_LAST_LOCK_EN
  ,
  input  logic             I0_last,
  input  logic             I1_last,
  output logic             O_last
`endif
);

  logic [WIDTH-1:0] o_q, o_d;
  logic             o_valid_q, o_valid_d;
  logic             s_q, s_d;
  logic             prio_q, prio_d;

  logic             pipe_ready;
  logic             grant_any;
  logic             grant_idx;
  logic             xfer;

`ifdef ARB2_MUX_LAST_LOCK_EN
  logic             last_q, last_d;
  logic             lock_valid_q, lock_valid_d;
  logic             lock_idx_q, lock_idx_d;
  logic             xfer_last;
`endif

  always_comb begin
    pipe_ready = !o_valid_q || O_ready;
    grant_any  = I0_valid || I1_valid;
    grant_idx  = (I0_valid && I1_valid) ? prio_q : I1_valid;
`ifdef ARB2_MUX_LAST_LOCK_EN
    // A held lock overrides arbitration, even while the owner is not valid.
    if (lock_valid_q) begin
      grant_any = 1'b1;
      grant_idx = lock_idx_q;
    end
`endif
    I0_ready = pipe_ready && grant_any && !grant_idx;
    I1_ready = pipe_ready && grant_any &&  grant_idx;
    xfer     = (I0_valid && I0_ready) || (I1_valid && I1_ready);

    o_d       = o_q;
    o_valid_d = o_valid_q;
    s_d       = s_q;
    prio_d    = prio_q;
`ifdef ARB2_MUX_LAST_LOCK_EN
    last_d       = last_q;
    lock_valid_d = lock_valid_q;
    lock_idx_d   = lock_idx_q;
    xfer_last    = grant_idx ? I1_last : I0_last;
`endif

    if (xfer) begin
      o_d       = grant_idx ? I1 : I0;
      s_d       = grant_idx;
      o_valid_d = 1'b1;
      prio_d    = ~grant_idx;
`ifdef ARB2_MUX_LAST_LOCK_EN
      // Only the lock owner can transfer while locked, so last alone decides the lock.
      last_d       = xfer_last;
      lock_valid_d = !xfer_last;
      lock_idx_d   = grant_idx;
`endif
    end else if (O_ready) begin
      o_valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      o_q       <= '0;
      o_valid_q <= 1'b0;
      s_q       <= 1'b0;
      prio_q    <= 1'b0;
`ifdef ARB2_MUX_LAST_LOCK_EN
      last_q       <= 1'b0;
      lock_valid_q <= 1'b0;
      lock_idx_q   <= 1'b0;
`endif
    end else begin
      o_q       <= o_d;
      o_valid_q <= o_valid_d;
      s_q       <= s_d;
      prio_q    <= prio_d;
`ifdef ARB2_MUX_LAST_LOCK_EN
      last_q       <= last_d;
      lock_valid_q <= lock_valid_d;
      lock_idx_q   <= lock_idx_d;
`endif
    end
  end

  assign O       = o_q;
  assign O_valid = o_valid_q;
  assign S       = s_q;
`ifdef ARB2_MUX_LAST_LOCK_EN
  assign O_last  = last_q;
`endif

endmodule

// File: doc/arb2_mux.md
Name: arb2_mux

Overview:
- Two-input round-robin arbitrated multiplexer with valid/ready handshakes on both inputs and a registered output stage.
- Sits directly upstream of the 2:1 select-mux consumers. It chooses which of two producers drives a shared downstream channel and exposes the winning index as a select.
- The datapath select is internal, derived from the arbiter. The output is a single-entry pipeline register.

Parameters:
- WIDTH, 8, data width of I0, I1, O.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RESETN  input  1  synchronous reset, active-low; sampled on rising CLK edge.
- I0  input  WIDTH  channel 0 data.
- I0_valid  input  1  channel 0 data valid.
- I0_ready  output  1  channel 0 accept; transfer when I0_valid && I0_ready.
- I1  input  WIDTH  channel 1 data.
- I1_valid  input  1  channel 1 data valid.
- I1_ready  output  1  channel 1 accept.
- O  output  WIDTH  registered output data.
- O_valid  output  1  output holds valid data.
- O_ready  input  1  downstream accept; transfer when O_valid && O_ready.
- S  output  1  source index of the word currently held in O (0 = I0, 1 = I1).

Behaviour:
- Reset (RESETN=0 at edge): O=0, O_valid=0, S=0, priority pointer prio=0 (I0 preferred). Reset wins over any simultaneous handshake. Mid-operation reset drops the held word without further transfer.
- pipe_ready = !O_valid || O_ready (combinational). The register accepts a new word when empty or draining in the same cycle.
- Grant (combinational):
  - only I0_valid -> g=0.
  - only I1_valid -> g=1.
  - both -> g=prio.
  - neither -> no grant.
- Ready outputs:
  - I0_ready = pipe_ready && grant present && g==0.
  - I1_ready likewise for g==1.
  - Ready never asserts for a non-granted channel. Ready may depend combinationally on the valids and O_ready.
- On a transfer from channel k: O<=Ik, S<=k, O_valid<=1, prio<=~k. Latency is one cycle from input transfer to O_valid.
- O_ready=1 with no input transfer: O_valid<=0. O and S hold their values.
- Simultaneous drain and fill: O_valid stays 1 and the new word replaces the old. Full throughput is 1 word/cycle.
- Stall (O_valid=1, O_ready=0): O, S, O_valid hold. Both input readies are 0. prio holds.
- prio changes only on an input transfer, never on idle cycles.
- Fairness: with both inputs continuously valid and O_ready=1, grants alternate 0,1,0,1...

Optional Feature:
- Macro ARB2_MUX_LAST_LOCK_EN.
- When defined:
  - Adds ports I0_last, I1_last (input 1) and O_last (output 1, reset 0, registered alongside O).
  - Adds a lock state: lock_valid (reset 0) and lock_idx.
  - A transfer from k with Ik_last=0 sets lock_valid=1, lock_idx=k.
  - While locked, grant is lock_idx only, even if that channel is not valid; the other channel's ready stays 0.
  - A transfer from lock_idx with last=1 clears the lock.
  - prio still updates to ~k on every transfer.
  - Reset clears the lock.
- When undefined: no last ports, no lock state; behaviour exactly as above.

Test Plan:
- Reset: hold RESETN=0 for 2 cycles with I0_valid=1, I0=0xAA -> O=0x00, O_valid=0, S=0, I0_ready=0 on the cycle after release sample. First accept occurs on the first edge with RESETN=1.
- Single channel: I1_valid=1, I1=0x5C, O_ready=1 -> I1_ready=1; next cycle O=0x5C, O_valid=1, S=1; then prio=0.
- Contention alternation: both valid continuously, I0 streaming 0x10,0x11,... and I1 streaming 0x20,0x21,..., O_ready=1 -> O sequence 0x10,0x20,0x11,0x21. S toggles 0,1,0,1. One word per cycle.
- Backpressure: O holds 0x33 with O_ready=0 for 3 cycles while both inputs are valid -> O, S, O_valid stable; I0_ready=I1_ready=0. When O_ready=1, the same-cycle refill occurs with no bubble.
- Reset mid-stall: O_valid=1, O=0x77, O_ready=0, RESETN=0 for one edge -> O_valid=0, O=0, prio=0. The word is never transferred.
- ARB2_MUX_LAST_LOCK_EN:
  - I0 sends a 3-beat packet (last=0,0,1) with a gap cycle where I0_valid=0, while I1_valid=1 throughout.
  - Required: I1_ready=0 for the whole packet, including the gap. I1 is granted on the cycle after I0's last beat transfers. O_last=1 on the third O word.
